// File: rtl/mult_share_arbiter_pkg.sv
// Shared state encoding, default sizes and owner-id width helper for mult_share_arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_WIDTH          = 32;
  localparam int DEF_TIMEOUT_CYCLES = 128;

  // Owner ids need at least one bit, even when only one requester exists.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Client and multiplier signals of mult_share_arbiter; slave is the arbiter's view,
// master is the view of the surrounding clients and multiplier.
interface mult_share_arbiter_if import mult_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic [2*WIDTH-1:0]       result;
  logic                     err;
  logic                     busy;
  logic                     mult_start;
  logic [WIDTH-1:0]         mult_a;
  logic [WIDTH-1:0]         mult_b;
  logic                     mult_abort;
  logic                     mult_valid;
  logic [2*WIDTH-1:0]       mult_product;

  modport slave (
    input  req, req_a, req_b, mult_valid, mult_product,
    output gnt, done, result, err, busy, mult_start, mult_a, mult_b, mult_abort
  );

  modport master (
    output req, req_a, req_b, mult_valid, mult_product,
    input  gnt, done, result, err, busy, mult_start, mult_a, mult_b, mult_abort
  );

endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin select: first set request found above rr_ptr, wrapping around.
module rr_arbiter import mult_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any_req,
  output logic [ID_W-1:0]    winner_id,
  output logic [NUM_REQ-1:0] winner_oh
);

  logic [ID_W-1:0] cand;

  // The last owner (rr_ptr) is checked last, so every other pending requester goes first.
  always_comb begin
    any_req   = 1'b0;
    winner_id = '0;
    winner_oh = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req         = 1'b1;
        winner_id       = cand;
        winner_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multi-cycle multiplier between NUM_REQ clients with round-robin arbitration.
// Optional WAIT-state watchdog enabled by defining MULT_TIMEOUT_EN.
module mult_share_arbiter import mult_arb_pkg::*; #(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                  clk,
  input logic                  reset,
  mult_share_arbiter_if.slave  bus
);

  localparam int ID_W = clog2(NUM_REQ);

  if (NUM_REQ < 1 || NUM_REQ > 8 || WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mult_share_arbiter: unsupported parameter combination");
  end

  state_e               state_q, state_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]     mult_a_q, mult_a_d;
  logic [WIDTH-1:0]     mult_b_q, mult_b_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_oh;
  logic                 any_req;
  logic [ID_W-1:0]      winner_id;
  logic [NUM_REQ-1:0]   winner_oh;
  logic                 timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (bus.req),
    .rr_ptr    (rr_ptr_q),
    .any_req   (any_req),
    .winner_id (winner_id),
    .winner_oh (winner_oh)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      mult_a_q <= '0;
      mult_b_q <= '0;
      result_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      result_q <= result_d;
      gnt_q    <= gnt_d;
    end
  end

  // A valid pulse in the expiry cycle takes precedence over the watchdog.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    result_d = result_q;
    gnt_d    = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d  = winner_id;
          mult_a_d = bus.req_a[winner_id*WIDTH +: WIDTH];
          mult_b_d = bus.req_b[winner_id*WIDTH +: WIDTH];
          gnt_d    = winner_oh;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.mult_valid) begin
          result_d = bus.mult_product;
          state_d  = DONE;
        end else if (timeout_hit) begin
          result_d = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        rr_ptr_d = owner_q;
        gnt_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_oh = '0;
    if (state_q == DONE) done_oh[owner_q] = 1'b1;
  end

`ifdef MULT_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             err_q, err_d;

  // Counter is zeroed in ISSUE so the first WAIT cycle counts as cycle zero.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;
    if (state_q == ISSUE) begin
      wd_cnt_d = '0;
      err_d    = 1'b0;
    end else if (state_q == WAIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (timeout_hit) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign timeout_hit    = (state_q == WAIT) && !bus.mult_valid &&
                          (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.mult_abort = timeout_hit;
  assign bus.err        = (state_q == DONE) && err_q;
`else
  assign timeout_hit    = 1'b0;
  assign bus.mult_abort = 1'b0;
  assign bus.err        = 1'b0;
`endif

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_oh;
  assign bus.result     = result_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.mult_start = (state_q == ISSUE);
  assign bus.mult_a     = mult_a_q;
  assign bus.mult_b     = mult_b_q;

endmodule
